// File: rtl/rom_read_cache_if.sv
// rom_read_cache_if
//   Toggle-handshake ROM read bus. A request is pending while req != ack.
//   The requester (master) toggles req with a stable word address a; the
//   responder (slave) returns data on q and copies req into ack when done.
//
//   req  master -> slave   toggle request
//   a    master -> slave   23-bit word address, held while pending
//   ack  slave  -> master  toggle acknowledge
//   q    slave  -> master  16-bit read data
interface rom_read_cache_if;
  logic        req;
  logic        ack;
  logic [22:0] a;
  logic [15:0] q;

  modport master (output req, output a, input ack, input q);
  modport slave  (input req, input a, output ack, output q);
endinterface

// File: rtl/rom_read_cache.sv
// rom_read_cache
//   Direct-mapped, one-word-per-line read cache between the ROM consumer
//   (68k / VDP DMA) and the SDRAM ROM read port, with optional sequential
//   prefetch of address+1 after every miss fill.
//
//   clk      system / SDRAM clock
//   reset_n  asynchronous active-low reset
//   flush    one-cycle pulse, invalidates every line
//   cpu      toggle-handshake bus from the ROM consumer (slave side)
//   sd       toggle-handshake bus to the SDRAM ROM read port (master side)
//
//   Parameters: INDEX_BITS = log2(line count), PREFETCH = 1 enables the
//   address+1 fetch after each miss.
module rom_read_cache #(
  parameter int INDEX_BITS = 6,
  parameter bit PREFETCH   = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  rom_read_cache_if.slave  cpu,
  rom_read_cache_if.master sd
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 23 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, LOOKUP, FETCH, PREF} state_t;

  state_t                  state;
  logic [22:0]             req_addr;
  logic [LINES-1:0]        valid;
  logic                    discard;
  logic                    lookup_wait;

  logic [TAG_W+15:0]       mem [LINES];
  logic [TAG_W+15:0]       rd_word;

  logic [INDEX_BITS-1:0]   req_index;
  logic [TAG_W-1:0]        req_tag;
  logic [INDEX_BITS-1:0]   sd_index;
  logic [TAG_W-1:0]        sd_tag;
  logic                    sd_done;
  logic                    hit;
  logic                    fill_we;

  // sd.a always holds the address being filled (miss or prefetch), so the
  // fill is written at the index/tag of whatever is on the SDRAM bus.
  always_comb begin
    req_index = req_addr[INDEX_BITS-1:0];
    req_tag   = req_addr[22:INDEX_BITS];
    sd_index  = sd.a[INDEX_BITS-1:0];
    sd_tag    = sd.a[22:INDEX_BITS];
    sd_done   = (sd.ack == sd.req);
    hit       = valid[req_index] && (rd_word[TAG_W+15:16] == req_tag);
    fill_we   = ((state == FETCH) || (state == PREF)) && sd_done && !discard;
  end

  // Tag+data store: synchronous single-cycle read addressed by req_addr,
  // so the word for a new request is available one cycle after it is latched.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[sd_index] <= {sd_tag, sd.q};
    end
    rd_word <= mem[req_index];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      req_addr    <= '0;
      valid       <= '0;
      discard     <= 1'b0;
      lookup_wait <= 1'b0;
      cpu.ack     <= 1'b0;
      cpu.q       <= '0;
      sd.req      <= 1'b0;
      sd.a        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu.req != cpu.ack) begin
            req_addr    <= cpu.a;
            lookup_wait <= 1'b1;
            state       <= LOOKUP;
          end
        end
        LOOKUP: begin
          // First LOOKUP cycle only waits for the RAM read of req_addr.
          if (lookup_wait) begin
            lookup_wait <= 1'b0;
          end else if (hit) begin
            cpu.q   <= rd_word[15:0];
            cpu.ack <= cpu.req;
            state   <= IDLE;
          end else begin
            sd.a    <= req_addr;
            sd.req  <= ~sd.req;
            discard <= 1'b0;
            state   <= FETCH;
          end
        end
        FETCH: begin
          if (sd_done) begin
            cpu.q   <= sd.q;
            cpu.ack <= cpu.req;
            if (!discard) begin
              valid[sd_index] <= 1'b1;
            end
            if (PREFETCH) begin
              sd.a    <= req_addr + 23'd1;
              sd.req  <= ~sd.req;
              discard <= 1'b0;
              state   <= PREF;
            end else begin
              state <= IDLE;
            end
          end
        end
        PREF: begin
          if (sd_done) begin
            if (!discard) begin
              valid[sd_index] <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Placed last so a flush overrides any valid bit set at the same edge;
      // an in-flight fill is marked so it never becomes valid afterwards.
      if (flush) begin
        valid <= '0;
        if ((state == FETCH) || (state == PREF)) begin
          discard <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rom_read_cache.sv
// tb_rom_read_cache
//   Drives rom_read_cache with directed and randomized reads, models the
//   SDRAM ROM as a pure function of address with variable latency, and
//   predicts hits, misses and SDRAM traffic from an address-level model of
//   a direct-mapped cache with next-word prefetch.
module tb_rom_read_cache;

  localparam int LINES    = 64;
  localparam bit PREFETCH = 1'b1;

  logic clk;
  logic reset_n;
  logic flush;

  rom_read_cache_if cpu_bus ();
  rom_read_cache_if sd_bus ();

  rom_read_cache #(.INDEX_BITS(6), .PREFETCH(PREFETCH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .cpu     (cpu_bus.slave),
    .sd      (sd_bus.master)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: which full word address each line currently holds.
  bit          m_valid [LINES];
  logic [22:0] m_addr  [LINES];
  logic [22:0] exp_sd_q [$];
  int          exp_toggles = 0;
  int          sd_toggles  = 0;
  logic        last_sd_req = 1'b0;
  int          fixed_lat   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [22:0] a);
    if (a == 23'h000100) return 16'hBEEF;
    return a[15:0] ^ {a[22:16], a[8:0]} ^ 16'h3C5A;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_hit(input logic [22:0] a);
    int idx = int'(a) % LINES;
    return m_valid[idx] && (m_addr[idx] == a);
  endfunction

  function automatic void model_fill(input logic [22:0] a);
    int idx = int'(a) % LINES;
    m_valid[idx] = 1'b1;
    m_addr[idx]  = a;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endfunction

  // A miss costs one SDRAM read (plus one for the prefetch); a flush during
  // the miss fill leaves the missed word invalid but the prefetch still lands.
  function automatic void model_access(input logic [22:0] a, input bit flushed_mid);
    if (model_hit(a) && !flushed_mid) return;
    exp_sd_q.push_back(a);
    exp_toggles++;
    if (flushed_mid) model_clear();
    else model_fill(a);
    if (PREFETCH) begin
      exp_sd_q.push_back(a + 23'd1);
      exp_toggles++;
      model_fill(a + 23'd1);
    end
  endfunction

  // Count every sd_req toggle, sampled between clock edges.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (sd_bus.req !== last_sd_req) begin
        sd_toggles++;
        last_sd_req = sd_bus.req;
      end
    end
  end

  // SDRAM ROM responder: checks each request address against the expected
  // order and that the address is held until acknowledged.
  initial begin
    logic [22:0] captured;
    logic [22:0] expected;
    int          lat;
    sd_bus.ack = 1'b0;
    sd_bus.q   = '0;
    forever begin
      @(negedge clk);
      if (reset_n && (sd_bus.req !== sd_bus.ack)) begin
        captured = sd_bus.a;
        check_output("sd_req_expected", 32'(exp_sd_q.size() != 0), 32'd1);
        if (exp_sd_q.size() != 0) begin
          expected = exp_sd_q.pop_front();
          check_output("sd_a", 32'(captured), 32'(expected));
        end
        lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 8));
        repeat (lat) @(posedge clk);
        #1;
        check_output("sd_a_held", 32'(sd_bus.a), 32'(captured));
        sd_bus.q   = rom_word(captured);
        sd_bus.ack = sd_bus.req;
      end
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if ((sd_bus.req == sd_bus.ack) && (cpu_bus.req == cpu_bus.ack)) ok = 1'b1;
    end
    check_output("idle_timeout", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic issue(input logic [22:0] a);
    @(posedge clk);
    #1;
    cpu_bus.a   = a;
    cpu_bus.req = ~cpu_bus.req;
  endtask

  task automatic wait_ack(input logic [22:0] a, input bit chk_lat);
    int edges = 0;
    bit done  = 1'b0;
    while (!done && edges < 300) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (cpu_bus.ack == cpu_bus.req) done = 1'b1;
    end
    check_output("ack_timeout", 32'(done), 32'd1);
    if (done) begin
      check_output("read_data", 32'(cpu_bus.q), 32'(rom_word(a)));
      check_output("sd_toggles", 32'(sd_toggles), 32'(exp_toggles));
      if (chk_lat) check_output("hit_latency", 32'(edges), 32'd3);
    end
  endtask

  task automatic apply_stimulus(input logic [22:0] a, input bit idle_first);
    bit chk_lat;
    if (idle_first) wait_idle();
    chk_lat = idle_first && model_hit(a);
    model_access(a, 1'b0);
    issue(a);
    wait_ack(a, chk_lat);
  endtask

  task automatic do_flush();
    wait_idle();
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    model_clear();
  endtask

  task automatic flush_mid_fetch(input logic [22:0] a);
    do_flush();
    fixed_lat = 6;
    model_access(a, 1'b1);
    issue(a);
    fork
      wait_ack(a, 1'b0);
      begin
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clk);
          if (sd_bus.req !== sd_bus.ack) seen = 1'b1;
        end
        check_output("fetch_pending", 32'(seen), 32'd1);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
      end
    join
    fixed_lat = 0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [22:0] a;
    reset_n     = 1'b0;
    flush       = 1'b0;
    cpu_bus.req = 1'b0;
    cpu_bus.a   = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    repeat (10) @(negedge clk);
    check_output("reset_cpu_ack", 32'(cpu_bus.ack), 32'd0);
    check_output("reset_cpu_q", 32'(cpu_bus.q), 32'd0);
    check_output("reset_sd_req", 32'(sd_bus.req), 32'd0);
    check_output("reset_sd_a", 32'(sd_bus.a), 32'd0);
    check_output("reset_no_toggle", 32'(sd_toggles), 32'd0);

    $display("[TB] cold read, re-read hit, read during prefetch");
    fixed_lat = 6;
    apply_stimulus(23'h000100, 1'b1);
    apply_stimulus(23'h000100, 1'b1);
    do_flush();
    fixed_lat = 6;
    apply_stimulus(23'h000100, 1'b1);
    apply_stimulus(23'h000101, 1'b0);

    $display("[TB] address wrap prefetch");
    apply_stimulus(23'h7FFFFF, 1'b1);
    apply_stimulus(23'h000000, 1'b1);

    $display("[TB] index collision");
    do_flush();
    apply_stimulus(23'h000100, 1'b1);
    apply_stimulus(23'h000140, 1'b1);
    apply_stimulus(23'h000100, 1'b1);

    $display("[TB] flush during fetch");
    flush_mid_fetch(23'h000200);
    apply_stimulus(23'h000200, 1'b1);

    $display("[TB] randomized reads");
    fixed_lat = 0;
    for (int n = 0; n < 80; n++) begin
      a = 23'($urandom_range(0, 160));
      if ($urandom_range(0, 3) == 0) a = a + 23'h7FFF80;
      if ($urandom_range(0, 11) == 0) do_flush();
      apply_stimulus(a, 1'($urandom_range(0, 1)));
    end

    wait_idle();
    check_output("final_sd_queue", 32'(exp_sd_q.size()), 32'd0);
    check_output("final_sd_toggles", 32'(sd_toggles), 32'(exp_toggles));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
